// File: rtl/axis_byte_packet_tx.sv
// axis_byte_packet_tx
//   Buffers a short byte message written by local control logic and sends it
//   as one AXI4-Stream packet (TVALID/TREADY handshake, TLAST on the last byte).
//   After the packet the buffer is empty again.
//
// Ports
//   ap_clk, ap_rst_n   clock, asynchronous active-low reset
//   wr_en, wr_data     append one byte to the buffer (only honoured in IDLE when not full)
//   start              single-cycle request to transmit the buffered bytes
//   m_TDATA/m_TVALID/m_TREADY/m_TLAST  AXI4-Stream master
//   count, full        bytes currently buffered, count == DEPTH
//   busy               high while a packet is being sent
//   done               one-cycle pulse after the final beat is accepted
//   overflow           sticky flag for any dropped write; cleared only by reset
module axis_byte_packet_tx #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  output logic [DATA_W-1:0]        m_TDATA,
  output logic                     m_TVALID,
  input  logic                     m_TREADY,
  output logic                     m_TLAST,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     pkt_len_q, pkt_len_d;
  logic [CW-1:0]     count_d;
  logic [DATA_W-1:0] tdata_d;
  logic              tvalid_d;
  logic              tlast_d;
  logic              full_d;
  logic              busy_d;
  logic              done_d;
  logic              overflow_d;
  logic              wr_fire;

  logic [DATA_W-1:0] mem [DEPTH];

  // Message storage; no reset needed, contents are only read below count.
  always_ff @(posedge ap_clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_len_q <= '0;
      count     <= '0;
      m_TDATA   <= '0;
      m_TVALID  <= 1'b0;
      m_TLAST   <= 1'b0;
      full      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_len_q <= pkt_len_d;
      count     <= count_d;
      m_TDATA   <= tdata_d;
      m_TVALID  <= tvalid_d;
      m_TLAST   <= tlast_d;
      full      <= full_d;
      busy      <= busy_d;
      done      <= done_d;
      overflow  <= overflow_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_len_d  = pkt_len_q;
    count_d    = count;
    tdata_d    = m_TDATA;
    tvalid_d   = m_TVALID;
    tlast_d    = m_TLAST;
    done_d     = 1'b0;
    overflow_d = overflow;
    wr_fire    = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (!full) begin
            wr_fire  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Packet length is the pre-write count; a same-cycle write is left
        // out of the packet and discarded when the buffer is cleared.
        if (start && (count != '0)) begin
          tdata_d   = mem[0];
          tlast_d   = (count == CW'(1));
          tvalid_d  = 1'b1;
          rd_ptr_d  = AW'(1);
          pkt_len_d = count;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (wr_en) begin
          overflow_d = 1'b1;
        end
        if (m_TVALID && m_TREADY) begin
          if (m_TLAST) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            tdata_d  = mem[rd_ptr_q];
            tlast_d  = (CW'(rd_ptr_q) == (pkt_len_q - CW'(1)));
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    full_d = (count_d == CW'(DEPTH));
    busy_d = (state_d == SEND);
  end

endmodule

// File: tb/tb_axis_byte_packet_tx.sv
// Randomised self-checking bench for axis_byte_packet_tx. A queue holds the
// bytes the sender should emit; each packet is compared beat by beat.
module tb_axis_byte_packet_tx;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [DATA_W-1:0] m_TDATA;
  logic              m_TVALID;
  logic              m_TREADY;
  logic              m_TLAST;
  logic [CW-1:0]     count;
  logic              full;
  logic              busy;
  logic              done;
  logic              overflow;

  axis_byte_packet_tx #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .start    (start),
    .m_TDATA  (m_TDATA),
    .m_TVALID (m_TVALID),
    .m_TREADY (m_TREADY),
    .m_TLAST  (m_TLAST),
    .count    (count),
    .full     (full),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes buffered so far and the sticky overflow flag.
  logic [7:0] model_q[$];
  bit         model_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge ap_clk);
    wr_en   = 1'b1;
    wr_data = b;
    model_write(b);
    @(negedge ap_clk);
    wr_en = 1'b0;
    check("wr_count", 32'(count), 32'(model_q.size()));
    check("wr_full", 32'(full), 32'(model_q.size() == DEPTH));
    check("wr_ovf", 32'(overflow), 32'(model_ovf));
  endtask

  // mode: 0 = ready always, 1 = ready pattern 1,0,0,..., 2 = random ready
  task automatic run_packet(input string tag, input int mode,
                            input bit wr_in_send, input bit wr_with_start);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         valid_cycles;
    int         cyc;
    int         idx;
    bit         finished;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    exp_q        = model_q;
    valid_cycles = 0;
    cyc          = 0;
    finished     = 1'b0;
    prev_stall   = 1'b0;
    prev_data    = '0;
    prev_last    = 1'b0;

    @(negedge ap_clk);
    check({tag, "_idle_valid"}, 32'(m_TVALID), 32'd0);
    start = 1'b1;
    if (wr_with_start) begin
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      model_write(wr_data);
    end

    while (!finished && cyc < 200) begin
      @(negedge ap_clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (wr_in_send && cyc == 0) begin
        wr_en     = 1'b1;
        wr_data   = 8'($urandom);
        model_ovf = 1'b1;
      end
      case (mode)
        0:       m_TREADY = 1'b1;
        1:       m_TREADY = (cyc % 3 == 0);
        default: m_TREADY = 1'($urandom_range(0, 1));
      endcase

      check({tag, "_valid"}, 32'(m_TVALID), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      if (prev_stall) begin
        check({tag, "_hold_data"}, 32'(m_TDATA), 32'(prev_data));
        check({tag, "_hold_last"}, 32'(m_TLAST), 32'(prev_last));
      end
      if (m_TVALID) valid_cycles++;
      if (m_TVALID && m_TREADY) begin
        got_q.push_back(m_TDATA);
        idx = got_q.size() - 1;
        if (idx < exp_q.size()) begin
          check({tag, "_data"}, 32'(m_TDATA), 32'(exp_q[idx]));
          check({tag, "_last"}, 32'(m_TLAST), 32'(idx == exp_q.size() - 1));
        end else begin
          check({tag, "_extra_beat"}, 32'(got_q.size()), 32'(exp_q.size()));
        end
        if (m_TLAST) finished = 1'b1;
      end
      prev_stall = m_TVALID && !m_TREADY;
      prev_data  = m_TDATA;
      prev_last  = m_TLAST;
      cyc++;
    end
    if (!finished) check({tag, "_timeout"}, 32'(finished), 32'd1);

    @(negedge ap_clk);
    wr_en = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_valid_end"}, 32'(m_TVALID), 32'd0);
    check({tag, "_last_end"}, 32'(m_TLAST), 32'd0);
    check({tag, "_count_end"}, 32'(count), 32'd0);
    check({tag, "_full_end"}, 32'(full), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
    check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    if (mode == 0) check({tag, "_throughput"}, 32'(valid_cycles), 32'(exp_q.size()));
    @(negedge ap_clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    model_q.delete();
  endtask

  task automatic write_hello();
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    foreach (hello[i]) write_byte(hello[i]);
  endtask

  initial begin
    int len;
    ap_rst_n = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    start    = 1'b0;
    m_TREADY = 1'b1;

    #1;
    check("rst_tdata", 32'(m_TDATA), 32'd0);
    check("rst_tvalid", 32'(m_TVALID), 32'd0);
    check("rst_tlast", 32'(m_TLAST), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single byte.
    write_byte(8'h68);
    run_packet("single", 0, 1'b0, 1'b0);

    // HELLO without and with backpressure.
    write_hello();
    run_packet("hello", 0, 1'b0, 1'b0);
    write_hello();
    run_packet("hello_bp", 1, 1'b0, 1'b0);

    // Write coinciding with start is excluded from the packet.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    run_packet("wr_start", 2, 1'b0, 1'b1);

    // Start with an empty buffer is ignored.
    @(negedge ap_clk);
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    repeat (3) begin
      check("empty_valid", 32'(m_TVALID), 32'd0);
      check("empty_done", 32'(done), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);
      @(negedge ap_clk);
    end

    // Fill past capacity: 17th byte dropped, overflow sticks.
    for (int i = 1; i <= DEPTH + 1; i++) write_byte(8'(i));
    run_packet("full", 0, 1'b0, 1'b0);

    // Write while sending is dropped.
    write_hello();
    run_packet("wr_send", 1, 1'b1, 1'b0);

    // Randomised packets.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < len; i++) write_byte(8'($urandom));
      run_packet("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
    end

    // Reset mid-packet after two accepted beats.
    write_hello();
    @(negedge ap_clk);
    start    = 1'b1;
    m_TREADY = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_TVALID), 32'd0);
    check("mid_rst_last", 32'(m_TLAST), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge ap_clk);
    check("mid_rst_done", 32'(done), 32'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_valid", 32'(m_TVALID), 32'd0);
    write_byte(8'h41);
    run_packet("after_rst", 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
